// File: rtl/demux_2bit.sv
// ---------------------------------------------------------------------------
// demux_2bit
//
// Registered 1-to-4 demultiplexer with a valid/ready handshake on the input
// and on each of the four outputs. A word accepted on the input stream is
// steered by `select` into a one-deep holding register for that port. The
// register presents the word until its consumer takes it. A port that is
// drained and reloaded in the same cycle delivers back-to-back words.
//
// Parameters
//   word_size    : data width of input_data and of every output_data<i>
//   count_width  : width of the accepted-word counter
//
// Ports (bit i of each 4-bit vector belongs to port i)
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   input_data     in   word to be routed
//   select         in   destination port index 0..3
//   in_valid       in   input_data/select are valid this cycle
//   in_ready       out  the input word is taken this cycle if in_valid=1
//   output_data0-3 out  holding register of port 0..3
//   out_valid      out  holding register i holds an undelivered word
//   out_ready      in   consumer i takes output_data<i> this cycle
//   accept_count   out  words accepted since reset, modulo 2^count_width
// ---------------------------------------------------------------------------
module demux_2bit #(
    parameter int word_size   = 32,
    parameter int count_width = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [word_size-1:0]   input_data,
    input  logic [1:0]             select,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [word_size-1:0]   output_data0,
    output logic [word_size-1:0]   output_data1,
    output logic [word_size-1:0]   output_data2,
    output logic [word_size-1:0]   output_data3,
    output logic [3:0]             out_valid,
    input  logic [3:0]             out_ready,
    output logic [count_width-1:0] accept_count
);

    localparam int num_ports = 4;

    // Each holding register is a two-state machine: EMPTY or FULL.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } port_state_e;

    port_state_e                state_q [num_ports];
    port_state_e                state_d [num_ports];
    logic [word_size-1:0]       data_q  [num_ports];
    logic [num_ports-1:0]       load;
    logic [num_ports-1:0]       drain;
    logic                       accept;

    // -----------------------------------------------------------------------
    // Handshake decode and next-state logic.
    // in_ready looks only at the addressed port, so a full port with a
    // stalled consumer blocks just the words aimed at it. A port that is
    // being drained this cycle can take a new word at the same edge.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // skipped an assignment would infer a latch.
        in_ready = ~out_valid[select] | out_ready[select];
        accept   = in_valid & in_ready;
        load     = '0;
        drain    = '0;
        for (int i = 0; i < num_ports; i++) begin
            state_d[i] = state_q[i];
            load[i]    = accept && (select == 2'(i));
            drain[i]   = out_valid[i] & out_ready[i];
            // A reload wins over a drain: the port stays FULL with new data.
            if (load[i]) begin
                state_d[i] = FULL;
            end else if (drain[i]) begin
                state_d[i] = EMPTY;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State, data and counter registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset along with the state bits
        // because their reset value of zero is visible on the outputs.
        if (reset) begin
            for (int i = 0; i < num_ports; i++) begin
                // NOTE: non-blocking assignments keep every register
                // updating from the values present before this edge.
                state_q[i] <= EMPTY;
                data_q[i]  <= '0;
            end
            accept_count <= '0;
        end else begin
            for (int i = 0; i < num_ports; i++) begin
                state_q[i] <= state_d[i];
                // Data only moves on a load; a drain leaves it in place.
                if (load[i]) begin
                    data_q[i] <= input_data;
                end
            end
            // Wraps silently at 2^count_width.
            if (accept) begin
                accept_count <= accept_count + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < num_ports; i++) begin
            out_valid[i] = (state_q[i] == FULL);
        end
    end

    assign output_data0 = data_q[0];
    assign output_data1 = data_q[1];
    assign output_data2 = data_q[2];
    assign output_data3 = data_q[3];

endmodule

// File: tb/tb_demux_2bit.sv
// ---------------------------------------------------------------------------
// tb_demux_2bit
//
// Self-checking bench for demux_2bit. The DUT is built with count_width=4 so
// the accepted-word counter can be wrapped in a short run. A reference model
// of the four ports, plus one scoreboard queue per port, is updated from the
// stimulus; queued words are popped and compared when a port is drained.
// ---------------------------------------------------------------------------
module tb_demux_2bit;

    localparam int ws = 32;
    localparam int cw = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [ws-1:0] input_data;
    logic [1:0]    select;
    logic          in_valid;
    logic          in_ready;
    logic [ws-1:0] output_data0, output_data1, output_data2, output_data3;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [cw-1:0] accept_count;

    demux_2bit #(.word_size(ws), .count_width(cw)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_data   (input_data),
        .select       (select),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .output_data0 (output_data0),
        .output_data1 (output_data1),
        .output_data2 (output_data2),
        .output_data3 (output_data3),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .accept_count (accept_count)
    );

    always #5 clk = ~clk;

    logic [ws-1:0] od [4];
    assign od[0] = output_data0;
    assign od[1] = output_data1;
    assign od[2] = output_data2;
    assign od[3] = output_data3;

    // Reference model and scoreboard.
    logic [3:0]    exp_valid = '0;
    logic [ws-1:0] exp_data [4] = '{default: '0};
    int            exp_count = 0;
    logic [ws-1:0] sb [4][$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [ws-1:0] obs,
                         input logic [ws-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare DUT outputs against the model at the falling
    // edge, advance the model with the inputs in effect, then cross the
    // rising edge and return 1 time unit later so new inputs can be driven.
    task automatic tick();
        logic       exp_rdy;
        logic       acc;
        logic [ws-1:0] front;
        @(negedge clk);
        exp_rdy = !exp_valid[select] || out_ready[select];
        check("in_ready", ws'(in_ready), ws'(exp_rdy));
        check("out_valid", ws'(out_valid), ws'(exp_valid));
        check("accept_count", ws'(accept_count), ws'(exp_count % 16));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("output_data%0d", i), od[i], exp_data[i]);
            if (!reset && exp_valid[i] && out_ready[i]) begin
                if (sb[i].size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_underflow%0d: observed=drain expected=no_word", i);
                end else begin
                    front = sb[i].pop_front();
                    check($sformatf("delivered%0d", i), od[i], front);
                end
            end
        end
        if (reset) begin
            exp_valid = '0;
            exp_count = 0;
            for (int i = 0; i < 4; i++) begin
                exp_data[i] = '0;
                sb[i].delete();
            end
        end else begin
            acc = in_valid && exp_rdy;
            for (int i = 0; i < 4; i++) begin
                if (acc && select == 2'(i)) begin
                    exp_valid[i] = 1'b1;
                    exp_data[i]  = input_data;
                    sb[i].push_back(input_data);
                end else if (exp_valid[i] && out_ready[i]) begin
                    exp_valid[i] = 1'b0;
                end
            end
            if (acc) exp_count = (exp_count + 1) % 16;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [ws-1:0] d);
        select     = sel;
        input_data = d;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        input_data = '0;
        select     = 2'd0;
        in_valid   = 1'b0;
        out_ready  = 4'b0000;

        // Reset for two cycles, then idle.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("rst_in_ready", ws'(in_ready), 32'd1);

        // Single routing to port 2, held for 5 cycles, then drained.
        send(2'd2, 32'hDEADBEEF);
        check("route_valid", ws'(out_valid), 32'h4);
        check("route_data2", output_data2, 32'hDEADBEEF);
        check("route_count", ws'(accept_count), 32'd1);
        repeat (5) tick();
        out_ready = 4'b0100;
        tick();
        out_ready = 4'b0000;
        check("route_drained", ws'(out_valid), 32'h0);

        // Backpressure: port 1 full and stalled, word for port 1 refused,
        // then redirected to port 3.
        send(2'd1, 32'h11);
        select     = 2'd1;
        input_data = 32'h22;
        in_valid   = 1'b1;
        #1;
        check("bp_in_ready_low", ws'(in_ready), 32'd0);
        tick();
        check("bp_data1_held", output_data1, 32'h11);
        check("bp_count_held", ws'(accept_count), 32'd2);
        select = 2'd3;
        #1;
        check("bp_in_ready_high", ws'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_data3", output_data3, 32'h22);
        out_ready = 4'b1010;
        tick();
        out_ready = 4'b0000;

        // Simultaneous drain and reload on port 0, then an 8-word stream.
        send(2'd0, 32'hA);
        out_ready = 4'b0001;
        send(2'd0, 32'hB);
        check("reload_valid0", ws'(out_valid[0]), 32'd1);
        check("reload_data0", output_data0, 32'hB);
        for (int k = 1; k <= 8; k++) send(2'd0, ws'(k));
        tick();
        out_ready = 4'b0000;
        check("stream_empty", ws'(out_valid), 32'h0);

        // Counter wrap with count_width=4.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 4'b0100;
        for (int k = 1; k <= 17; k++) begin
            send(2'd2, ws'(32'h100 + k));
            if (k >= 15) check($sformatf("wrap_after_%0d", k),
                               ws'(accept_count), ws'(k % 16));
        end
        tick();
        out_ready = 4'b0000;

        // Reset mid-operation: ports 0 and 3 full, accept pending on port 1.
        send(2'd0, 32'hC0C0);
        send(2'd3, 32'hC3C3);
        select     = 2'd1;
        input_data = 32'hC1C1;
        in_valid   = 1'b1;
        reset      = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_valid", ws'(out_valid), 32'h0);
        check("mid_rst_count", ws'(accept_count), 32'd0);
        check("mid_rst_data0", output_data0, 32'h0);
        check("mid_rst_data1", output_data1, 32'h0);
        check("mid_rst_data3", output_data3, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_2bit.md
# demux_2bit

Registered 1-to-4 demultiplexer with per-port valid/ready handshakes: the distribution-side counterpart of the 4:1 word selector in the CPU datapath. It accepts one word per cycle on a single input stream and steers it, by a 2-bit select, into one of four one-deep holding registers. Each register presents its word to a downstream consumer until that consumer takes it. It sits between a result producer (ALU / load unit) and up to four independent sinks (register write port, store buffer, branch unit, debug tap).

## Interface
Parameters:
- word_size, 32, data width of input and every output port
- count_width, 16, width of the accepted-word counter

Ports (bit i of every 4-bit vector belongs to port i):
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clk
- input_data  in  word_size  word to be routed
- select  in  2  destination port index, 0..3
- in_valid  in  1  input_data/select are valid this cycle
- in_ready  out  1  block will take the input word this cycle if in_valid=1
- output_data0..output_data3  out  word_size  holding register of port 0..3
- out_valid  out  4  holding register i holds an undelivered word
- out_ready  in  4  consumer i takes output_data<i> this cycle if out_valid[i]=1
- accept_count  out  count_width  number of input words accepted since reset, modulo 2^count_width

## Operation
- Per port i: state bit out_valid[i] (EMPTY=0 / FULL=1) plus a data register output_data<i>.
- in_ready = ~out_valid[select] | out_ready[select]. This is combinational from select, out_valid and out_ready. It does not depend on in_valid.
- accept = in_valid & in_ready.
- drain[i] = out_valid[i] & out_ready[i].
- Next-state for port i at each rising edge, with reset=0:
  - accept and select==i: output_data<i> <= input_data; out_valid[i] <= 1. This applies whether or not drain[i] occurs in the same cycle: drain and reload together give back-to-back delivery.
  - otherwise, drain[i]: out_valid[i] <= 0; output_data<i> keeps its value.
  - otherwise: hold.
- Ports not addressed by select are unaffected by the input side. Their drains proceed independently in the same cycle.
- While out_valid[i]=1 and drain[i]=0, output_data<i> is stable.
- select and input_data are don't-care when in_valid=0. A word presented with in_ready=0 is not taken, and the producer must hold it.
- accept_count increments by 1 on every accept. It wraps from 2^count_width-1 to 0 with no flag.
- reset=1 at a rising edge, regardless of any accept/drain in that cycle:
  - out_valid <= 4'b0000
  - all output_data<i> <= 0
  - accept_count <= 0
  - Words held mid-operation are discarded.

## Timing
- Reset values: out_valid=0, output_data0..3=0, accept_count=0. in_ready is 1 after reset, because every port is EMPTY.
- Latency is 1 cycle from the accepting edge to out_valid[select]=1 with the new word.
- Throughput to a single port is 1 word/cycle while out_ready of that port stays 1. It is 1 word per 2 cycles at best if out_ready is pulsed only when the port is FULL.
- No combinational path from in_valid to in_ready. No path from input_data to any output.
- Full port, out_ready=0: in_ready=0 for that select value only. Switching select to an EMPTY port raises in_ready in the same cycle.

## Test plan
- Reset then idle: assert reset 2 cycles -> out_valid=0000, all outputs 0, accept_count=0, in_ready=1.
- Single routing: select=2, input_data=32'hDEADBEEF, in_valid=1 for 1 cycle, out_ready=0000 -> next cycle out_valid=0100, output_data2=DEADBEEF, accept_count=1; port 2 holds DEADBEEF for 5 cycles until out_ready[2]=1, then out_valid=0000.
- Backpressure: port 1 FULL with 0x11, out_ready[1]=0, present select=1 data 0x22 -> in_ready=0, no accept, output_data1 stays 0x11, count unchanged; switch select=3 -> in_ready=1 and 0x22 lands in port 3.
- Simultaneous drain and reload: port 0 FULL with 0xA, out_ready[0]=1, accept select=0 data 0xB -> out_valid[0] stays 1, output_data0=0xB. Stream 8 words 1..8 to port 0 with out_ready[0]=1 -> one word delivered per cycle, in order.
- Counter wrap: count_width=4, accept 17 words -> accept_count reads 15 after 15 words, 0 after 16, 1 after 17.
- Reset mid-operation: ports 0 and 3 FULL, accept pending on port 1, assert reset -> next cycle out_valid=0000, outputs 0, accept_count=0, and no word lands in port 1.
